// File: rtl/cpu_loader.sv
// Host-side loader for the CPU accelerator: writes imem/dmem from a 16-bit command
// stream, runs the CPU until flag_done or a timeout, and returns the captured Out_R.
module cpu_loader #(
    parameter int DATAWIDTH = 16,
    parameter int TIMEOUT_W = 20,
    parameter int TIMEOUT   = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 ex_iwe,
    output logic [DATAWIDTH-1:0] ex_iaddr,
    output logic [DATAWIDTH-1:0] ex_idata,
    output logic                 ex_dwe,
    output logic [DATAWIDTH-1:0] ex_daddr,
    output logic [DATAWIDTH-1:0] ex_ddata,
    output logic                 cpu_rst_n,
    input  logic                 flag_done,
    input  logic [DATAWIDTH-1:0] Out_R,
    output logic                 res_valid,
    output logic [DATAWIDTH-1:0] res_data,
    output logic                 res_timeout,
    input  logic                 res_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RUN, WAIT_DONE, RESULT} state_t;

    localparam logic [TIMEOUT_W-1:0] LAST_CNT = TIMEOUT_W'(TIMEOUT - 1);

    state_t                 state, state_nxt;
    logic                   target, target_nxt;
    logic [DATAWIDTH-2:0]   count, count_nxt;
    logic [DATAWIDTH-2:0]   index, index_nxt;
    logic [DATAWIDTH-1:0]   base, base_nxt;
    logic [TIMEOUT_W-1:0]   run_cnt, run_cnt_nxt;

    logic                   in_ready_nxt, cpu_rst_n_nxt, res_valid_nxt, busy_nxt;
    logic                   iwe_nxt, dwe_nxt, res_timeout_nxt;
    logic [DATAWIDTH-1:0]   iaddr_nxt, idata_nxt, daddr_nxt, ddata_nxt, res_data_nxt;
    logic [DATAWIDTH-1:0]   wr_addr;
    logic                   in_fire, res_fire;

    // A transfer on either port happens only in a cycle where valid && ready are both high;
    // the ready/valid outputs are registers, so they describe the current state.
    assign in_fire  = in_valid && in_ready;
    assign res_fire = res_valid && res_ready;

    always_comb begin
        state_nxt       = state;
        target_nxt      = target;
        count_nxt       = count;
        index_nxt       = index;
        base_nxt        = base;
        run_cnt_nxt     = run_cnt;
        iwe_nxt         = 1'b0;
        dwe_nxt         = 1'b0;
        iaddr_nxt       = ex_iaddr;
        idata_nxt       = ex_idata;
        daddr_nxt       = ex_daddr;
        ddata_nxt       = ex_ddata;
        res_data_nxt    = res_data;
        res_timeout_nxt = res_timeout;
        wr_addr         = base + {1'b0, index};

        case (state)
            IDLE: begin
                if (in_fire) begin
                    if (in_data == '1) begin
                        state_nxt = RUN;
                    end else begin
                        target_nxt = in_data[DATAWIDTH-1];
                        count_nxt  = in_data[DATAWIDTH-2:0];
                        state_nxt  = ADDR;
                    end
                end
            end
            ADDR: begin
                if (in_fire) begin
                    base_nxt  = in_data;
                    index_nxt = '0;
                    state_nxt = (count == '0) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (in_fire) begin
                    if (target) begin
                        dwe_nxt   = 1'b1;
                        daddr_nxt = wr_addr;
                        ddata_nxt = in_data;
                    end else begin
                        iwe_nxt   = 1'b1;
                        iaddr_nxt = wr_addr;
                        idata_nxt = in_data;
                    end
                    index_nxt = index + 1'b1;
                    if (index == count - 1'b1) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RUN: begin
                run_cnt_nxt = '0;
                state_nxt   = WAIT_DONE;
            end
            WAIT_DONE: begin
                // flag_done has priority over a coincident timeout
                if (flag_done) begin
                    res_data_nxt    = Out_R;
                    res_timeout_nxt = 1'b0;
                    state_nxt       = RESULT;
                end else if (run_cnt == LAST_CNT) begin
                    res_data_nxt    = Out_R;
                    res_timeout_nxt = 1'b1;
                    state_nxt       = RESULT;
                end else begin
                    run_cnt_nxt = run_cnt + 1'b1;
                end
            end
            RESULT: begin
                if (res_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Control outputs are registered copies of what the next state implies.
        in_ready_nxt  = (state_nxt == IDLE) || (state_nxt == ADDR) || (state_nxt == DATA);
        cpu_rst_n_nxt = (state_nxt == RUN) || (state_nxt == WAIT_DONE) || (state_nxt == RESULT);
        res_valid_nxt = (state_nxt == RESULT);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state       <= IDLE;
            target      <= 1'b0;
            count       <= '0;
            index       <= '0;
            base        <= '0;
            run_cnt     <= '0;
            in_ready    <= 1'b1;
            ex_iwe      <= 1'b0;
            ex_iaddr    <= '0;
            ex_idata    <= '0;
            ex_dwe      <= 1'b0;
            ex_daddr    <= '0;
            ex_ddata    <= '0;
            cpu_rst_n   <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            target      <= target_nxt;
            count       <= count_nxt;
            index       <= index_nxt;
            base        <= base_nxt;
            run_cnt     <= run_cnt_nxt;
            in_ready    <= in_ready_nxt;
            ex_iwe      <= iwe_nxt;
            ex_iaddr    <= iaddr_nxt;
            ex_idata    <= idata_nxt;
            ex_dwe      <= dwe_nxt;
            ex_daddr    <= daddr_nxt;
            ex_ddata    <= ddata_nxt;
            cpu_rst_n   <= cpu_rst_n_nxt;
            res_valid   <= res_valid_nxt;
            res_data    <= res_data_nxt;
            res_timeout <= res_timeout_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule
